instr_fetch_unit: RTL and testbench

Fetch stage of the RV32 core. Holds the PC, issues in-order word requests to instruction memory with a valid/ready handshake, and buffers returned words in a small FIFO. Presents {inst, inst_pc} to the decode stage with valid/ready. Handles control-flow redirects by flushing the buffer and discarding stale in-flight responses.

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/ifetch_fifo.sv | 59 +++++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
package ifetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0]   PC_STEP  = 32'd4;

    typedef enum logic [0:0] {
        FETCH,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
interface instr_fetch_unit_if;
    import ifetch_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries; flush wins over push, push+pop legal when full or empty.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           wdata_i,
    output fetch_entry_t           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic         do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 fetch stage: credit-limited imem requests, instruction buffer, redirect flush.
// Optional IFETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module instr_fetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH      = 2,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        imem,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [INST_W-1:0]         inst,
    output logic [XLEN-1:0]           inst_pc,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]               perf_fetched,
    output logic [31:0]               perf_stall
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, last_pc_q;
    logic [CW-1:0]   out_q, out_d, fifo_count, count_d;
    logic            req_valid_q, req_valid_d;
    logic            req_acc, rsp, push, pop, fifo_full, fifo_empty;
    fetch_entry_t    push_entry, head;

    assign req_acc = req_valid_q && imem.imem_req_ready;
    assign rsp     = imem.imem_rsp_valid;
    assign pop     = !fifo_empty && inst_ready;
    assign push    = rsp && (state_q == FETCH) && !redirect_valid && (!fifo_full || pop);

    // Responses are in order, so the oldest outstanding request sits out_q words behind pc_q.
    assign push_entry.pc   = pc_q - (XLEN'(out_q) << 2);
    assign push_entry.inst = imem.imem_rsp_data;

    ifetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        out_d   = out_q + CW'(req_acc) - CW'(rsp);
        count_d = redirect_valid ? '0 : fifo_count + CW'(push) - CW'(pop);
        pc_d    = pc_q;
        if (redirect_valid) pc_d = redirect_pc & ~XLEN'(3);
        else if (req_acc)   pc_d = pc_q + PC_STEP;

        state_d = state_q;
        unique case (state_q)
            FETCH:   if (redirect_valid && (out_d != '0)) state_d = FLUSH;
            FLUSH:   if (out_d == '0) state_d = FETCH;
            default: state_d = FETCH;
        endcase

        // Registered request valid: credit is evaluated on next-state occupancy.
        req_valid_d = (state_d == FETCH)
                    && (({1'b0, out_d} + {1'b0, count_d}) < (CW+1)'(FIFO_DEPTH))
                    && (out_d < CW'(MAX_OUTSTANDING));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            out_q       <= '0;
            req_valid_q <= 1'b0;
            last_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_q       <= out_d;
            req_valid_q <= req_valid_d;
            if (!fifo_empty) last_pc_q <= head.pc;
        end
    end

    assign imem.imem_req_valid = req_valid_q;
    assign imem.imem_req_addr  = pc_q;
    assign inst_valid          = !fifo_empty;
    assign inst                = fifo_empty ? NOP_INST : head.inst;
    assign inst_pc             = fifo_empty ? last_pc_q : head.pc;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(pop);
            perf_stall_q   <= perf_stall_q + 32'(fifo_empty && (state_q != FLUSH));
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order imem model, scoreboard of accepted fetches, redirect table.
module tb_instr_fetch_unit;
    import ifetch_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; int acc_cyc; } exp_t;
    typedef struct { logic [31:0] rpc; logic [31:0] exp_addr; int settle; int lat; } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid, inst_ready, redirect_valid;
    logic [31:0] inst, inst_pc, redirect_pc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC        (RPC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus.master),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_pops = 0;
    int          tb_out = 0;
    int          mem_lat = 0;
    bit          tb_flush = 1'b0;
    logic [31:0] exp_addr = RPC;
    logic [31:0] last_pop_pc = 32'h0;
    mreq_t       mem_q[$];
    exp_t        sb[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    vec_t        vecs[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory: in order, earliest one cycle after acceptance, never back-pressures.
    initial forever begin
        mreq_t m;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mem_q.delete();
            bus.imem_rsp_valid = 1'b0;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mdata(m.addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
    end

    // Monitor: handshakes sampled mid-cycle, scoreboard updated, redirect/flush tracked.
    always @(negedge clk) begin : mon
        bit   acc;
        bit   rsp;
        bit   pop;
        exp_t e;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        rsp = bus.imem_rsp_valid;
        pop = inst_valid && inst_ready;
        if (rst_n) begin
            if (pop) begin
                chk("sb_nonempty_on_pop", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst", inst, e.inst);
                    chk("min_latency", 32'((cyc - e.acc_cyc) >= 2), 1);
                end
                pop_log.push_back(inst_pc);
                last_pop_pc = inst_pc;
                n_pops++;
            end
            if (!inst_valid) chk("nop_when_empty", inst, NOP_INST);
            if (tb_flush) begin
                chk("no_req_in_flush", 32'(bus.imem_req_valid), 0);
                chk("no_inst_in_flush", 32'(inst_valid), 0);
            end
            if (bus.imem_req_valid) chk("max_outstanding", 32'(tb_out < int'(MAXO)), 1);
            if (acc) begin
                chk("req_addr", bus.imem_req_addr, exp_addr);
                exp_addr = exp_addr + 32'd4;
                mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + 1 + mem_lat});
                if (!redirect_valid)
                    sb.push_back('{pc: bus.imem_req_addr, inst: mdata(bus.imem_req_addr),
                                   acc_cyc: cyc});
                acc_log.push_back(bus.imem_req_addr);
            end
            tb_out = tb_out + int'(acc) - int'(rsp);
            if (redirect_valid) begin
                sb.delete();
                exp_addr = redirect_pc & 32'hFFFF_FFFC;
                tb_flush = (tb_out > 0);
            end else if (tb_flush && tb_out == 0) begin
                tb_flush = 1'b0;
            end
        end
    end

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
        acc_log.delete();
        pop_log.delete();
    endtask

    // First request and first delivered instruction after a redirect or reset.
    task automatic wait_first(input string nm, input logic [31:0] exp_a);
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            done = (acc_log.size() > 0) && (pop_log.size() > 0);
        end
        chk({nm, "_done"}, 32'(done), 1);
        if (done) begin
            chk({nm, "_addr"}, acc_log[0], exp_a);
            chk({nm, "_pc"}, pop_log[0], exp_a);
        end
    endtask

    initial begin
        bit          found;
        logic [31:0] hold_addr;
        logic [31:0] hold_pc;

        vecs[0] = '{rpc: 32'h0000_1003, exp_addr: 32'h0000_1000, settle: 3, lat: 0};
        vecs[1] = '{rpc: 32'h0000_2001, exp_addr: 32'h0000_2000, settle: 4, lat: 1};
        vecs[2] = '{rpc: 32'h8000_0042, exp_addr: 32'h8000_0040, settle: 5, lat: 2};
        vecs[3] = '{rpc: 32'h0000_0000, exp_addr: 32'h0000_0000, settle: 2, lat: 0};
        vecs[4] = '{rpc: 32'h7FFF_FFFF, exp_addr: 32'h7FFF_FFFC, settle: 6, lat: 1};

        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        inst_ready         = 1'b1;
        redirect_valid     = 1'b0;
        redirect_pc        = 32'h0;

        #3;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
        chk("rst_req_addr", bus.imem_req_addr, RPC);
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_inst", inst, NOP_INST);
        chk("rst_inst_pc", inst_pc, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;

        // Straight-line stream
        repeat (30) step();
        chk("stream_count", 32'(pop_log.size() >= 8), 1);
        if (pop_log.size() >= 3) begin
            chk("stream_pc0", pop_log[0], 32'h0);
            chk("stream_pc1", pop_log[1], 32'h4);
            chk("stream_pc2", pop_log[2], 32'h8);
        end

        // Decode stall: buffer fills, requests stop, everything holds
        inst_ready = 1'b0;
        repeat (10) step();
        chk("stall_buffered", sb.size(), DEPTH);
        chk("stall_no_req", 32'(bus.imem_req_valid), 0);
        chk("stall_inst_valid", 32'(inst_valid), 1);
        if (sb.size() > 0) chk("stall_head_pc", inst_pc, sb[0].pc);
        hold_addr = bus.imem_req_addr;
        hold_pc   = inst_pc;
        repeat (3) step();
        chk("stall_addr_hold", bus.imem_req_addr, hold_addr);
        chk("stall_pc_hold", inst_pc, hold_pc);
        pop_log.delete();
        inst_ready = 1'b1;
        repeat (20) step();
        chk("resume_pops", 32'(pop_log.size() >= 6), 1);
        if (pop_log.size() > 0) chk("resume_first_pc", pop_log[0], hold_pc);

        // Redirect with two requests in flight
        mem_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = (tb_out == 2);
        end
        chk("two_outstanding", 32'(tb_out), 2);
        do_redirect(32'h0000_1003);
        wait_first("redir_1003", 32'h0000_1000);

        for (int i = 0; i < 5; i++) begin
            mem_lat = vecs[i].lat;
            repeat (vecs[i].settle) step();
            do_redirect(vecs[i].rpc);
            wait_first($sformatf("vec%0d", i), vecs[i].exp_addr);
        end

        // Redirect coinciding with a request acceptance and a response
        mem_lat = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            #1;
            if (bus.imem_req_valid && bus.imem_req_ready && bus.imem_rsp_valid) begin
                found = 1'b1;
                do_redirect(32'h0000_3000);
            end
        end
        chk("coincide_found", 32'(found), 1);
        wait_first("coincide", 32'h0000_3000);

        // PC wrap
        do_redirect(32'hFFFF_FFFC);
        wait_first("wrap", 32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            found = (acc_log.size() >= 2);
            if (!found) step();
        end
        chk("wrap_second_seen", 32'(found), 1);
        if (found) chk("wrap_addr", acc_log[1], 32'h0000_0000);

        // Randomised handshakes and redirects
        for (int i = 0; i < 300; i++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready         = ($urandom_range(0, 3) != 0);
            mem_lat            = $urandom_range(0, 2);
            redirect_valid     = ($urandom_range(0, 15) == 0);
            redirect_pc        = $urandom();
            step();
        end
        redirect_valid     = 1'b0;
        bus.imem_req_ready = 1'b1;
        inst_ready         = 1'b1;
        mem_lat            = 0;
        repeat (10) step();

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", 32'(bus.imem_req_valid), 0);
        chk("arst_req_addr", bus.imem_req_addr, RPC);
        chk("arst_inst_valid", 32'(inst_valid), 0);
        chk("arst_inst", inst, NOP_INST);
        chk("arst_inst_pc", inst_pc, 32'h0);
        mem_q.delete();
        sb.delete();
        bus.imem_rsp_valid = 1'b0;
        tb_out   = 0;
        tb_flush = 1'b0;
        exp_addr = RPC;
        n_pops   = 0;
        repeat (2) step();
        #2;
        rst_n = 1'b1;
        acc_log.delete();
        pop_log.delete();
        wait_first("restart", RPC);

        // Drain: no new requests accepted, buffer empties, inst_pc holds
        bus.imem_req_ready = 1'b0;
        repeat (12) step();
        chk("drain_empty", 32'(inst_valid), 0);
        chk("drain_nop", inst, NOP_INST);
        chk("drain_pc_hold", inst_pc, last_pop_pc);
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'(n_pops));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
